// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver: synchronizes the codec serial port into clk, deserializes stereo
// words and buffers {left,right} pairs in a first-word-fall-through FIFO.
// Optional peak meter enabled by defining I2S_RX_PEAK_EN.
module i2s_adc_receiver #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_ADCLRCK,
  input  logic                          AUD_ADCDAT,
  input  logic                          read,
  output logic                          read_ready,
  output logic [DATA_W-1:0]             readdata_left,
  output logic [DATA_W-1:0]             readdata_right,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow
`ifdef I2S_RX_PEAK_EN
  ,
  input  logic                          peak_clr,
  output logic [DATA_W-2:0]             peak
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] MSB_ONLY = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {SYNC, SKIP, SHIFT, HOLD} state_t;

  state_t            state;
  logic [2:0]        bclk_sync;
  logic [2:0]        lrck_sync;
  logic [1:0]        dat_sync;
  logic              bclk_rise;
  logic              lrck_edge;
  logic              lrck_rise;
  logic              lrck_fall;
  logic              dat;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] left_word;
  logic              left_valid;
  logic              push;

  logic [DATA_W-1:0] mem_left  [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_right [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              do_push;
  logic              do_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[1:0], AUD_ADCLRCK};
      dat_sync  <= {dat_sync[0], AUD_ADCDAT};
    end
  end

  always_comb begin
    bclk_rise = bclk_sync[1] & ~bclk_sync[2];
    lrck_edge = lrck_sync[1] ^ lrck_sync[2];
    lrck_rise = lrck_edge & lrck_sync[1];
    lrck_fall = lrck_edge & ~lrck_sync[1];
    dat       = dat_sync[1];
    push      = lrck_fall && (state != SYNC) && left_valid;
  end

  // Bits land directly at the one-hot mask position, so a word cut short by an
  // LRCK edge is already left-aligned with zero-filled LSBs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SYNC;
      word       <= '0;
      mask       <= '0;
      left_word  <= '0;
      left_valid <= 1'b0;
    end else if (state == SYNC) begin
      if (lrck_fall) begin
        state <= SKIP;
        word  <= '0;
      end
    end else if (lrck_edge) begin
      if (lrck_rise) begin
        left_word  <= word;
        left_valid <= 1'b1;
      end
      state <= SKIP;
      word  <= '0;
      mask  <= '0;
    end else if (bclk_rise) begin
      case (state)
        SKIP: begin
          state <= SHIFT;
          mask  <= MSB_ONLY;
        end
        SHIFT: begin
          word <= word | (mask & {DATA_W{dat}});
          mask <= mask >> 1;
          if (mask[0]) state <= HOLD;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    full    = (count == (AW+1)'(FIFO_DEPTH));
    do_pop  = read && (count != '0);
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_left[wr_ptr]  <= left_word;
      mem_right[wr_ptr] <= word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    read_ready     = (count != '0);
    fill           = count;
    readdata_left  = read_ready ? mem_left[rd_ptr]  : '0;
    readdata_right = read_ready ? mem_right[rd_ptr] : '0;
  end

`ifdef I2S_RX_PEAK_EN
  logic [DATA_W-2:0] mag_left;
  logic [DATA_W-2:0] mag_right;
  logic [DATA_W-2:0] mag_max;

  function automatic logic [DATA_W-2:0] magnitude(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] n;
    n = -s;
    if (!s[DATA_W-1])     return s[DATA_W-2:0];
    else if (n[DATA_W-1]) return '1;
    else                  return n[DATA_W-2:0];
  endfunction

  always_comb begin
    mag_left  = magnitude(left_word);
    mag_right = magnitude(word);
    mag_max   = (mag_left > mag_right) ? mag_left : mag_right;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       peak <= '0;
    else if (peak_clr)                  peak <= '0;
    else if (do_push && mag_max > peak) peak <= mag_max;
  end
`endif

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed bench for i2s_adc_receiver: drives I2S frames at BCLK = clk/16 and
// checks FIFO contents, flags and reset behaviour with immediate assertions.
module tb_i2s_adc_receiver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bclk = 1'b0;
  logic        lrck = 1'b0;
  logic        dat = 1'b0;
  logic        read = 1'b0;
  logic        read_ready;
  logic [23:0] readdata_left;
  logic [23:0] readdata_right;
  logic [2:0]  fill;
  logic        overflow;
`ifdef I2S_RX_PEAK_EN
  logic        peak_clr = 1'b0;
  logic [22:0] peak;
`endif

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  i2s_adc_receiver #(.DATA_W(24), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .AUD_BCLK       (bclk),
    .AUD_ADCLRCK    (lrck),
    .AUD_ADCDAT     (dat),
    .read           (read),
    .read_ready     (read_ready),
    .readdata_left  (readdata_left),
    .readdata_right (readdata_right),
    .fill           (fill),
    .overflow       (overflow)
`ifdef I2S_RX_PEAK_EN
    ,
    .peak_clr       (peak_clr),
    .peak           (peak)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One BCLK period: data and LRCK change while BCLK is low.
  task automatic slot(input logic lr, input logic d);
    bclk = 1'b0;
    lrck = lr;
    dat  = d;
    repeat (8) @(negedge clk);
    bclk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Delay slot (driven 1 so a missed skip corrupts the word), data bits, then 1-padding.
  task automatic send_chan(input logic lr, input logic [23:0] data, input int nbits, input int slots);
    logic [23:0] d;
    d = data;
    slot(lr, 1'b1);
    for (int i = 0; i < slots - 1; i++)
      slot(lr, (i < nbits) ? d[23 - i] : 1'b1);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
    send_chan(1'b0, l, 24, 32);
    send_chan(1'b1, r, 24, 32);
  endtask

  task automatic tail();
    send_chan(1'b0, 24'h0, 0, 2);
  endtask

  task automatic preamble();
    repeat (2) slot(1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pop();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(read_ready), 0);
    check("rst_fill", 32'(fill), 0);
    check("rst_left", 32'(readdata_left), 0);
    check("rst_ovf", 32'(overflow), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame
    preamble();
    send_frame(24'h123456, 24'hABCDEF);
    tail();
    check("f1_ready", 32'(read_ready), 1);
    check("f1_left", 32'(readdata_left), 'h123456);
    check("f1_right", 32'(readdata_right), 'hABCDEF);
    check("f1_fill", 32'(fill), 1);
    pop();
    check("f1_pop_fill", 32'(fill), 0);
    check("f1_pop_ready", 32'(read_ready), 0);
    pop();
    check("empty_pop_fill", 32'(fill), 0);
    check("f1_ovf", 32'(overflow), 0);

    // Five frames into depth 4
    apply_reset();
    preamble();
    for (int i = 1; i <= 5; i++)
      send_frame(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    tail();
    check("of_fill", 32'(fill), 4);
    check("of_ovf", 32'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      check("of_left", 32'(readdata_left), 'h100000 + i);
      check("of_right", 32'(readdata_right), 'h200000 + i);
      pop();
    end
    check("of_empty", 32'(read_ready), 0);
    check("of_sticky", 32'(overflow), 1);

    // 16-bit words, LRCK toggles right after the 16th bit
    apply_reset();
    check("ovf_cleared", 32'(overflow), 0);
    preamble();
    send_chan(1'b0, 24'hBEEF00, 16, 17);
    send_chan(1'b1, 24'h123400, 16, 17);
    tail();
    check("w16_fill", 32'(fill), 1);
    check("w16_left", 32'(readdata_left), 'hBEEF00);
    check("w16_right", 32'(readdata_right), 'h123400);

    // Stream joined in the middle of a right word
    apply_reset();
    send_chan(1'b1, 24'hFFFFFF, 9, 10);
    send_frame(24'h0A0B0C, 24'h0D0E0F);
    tail();
    check("mid_fill", 32'(fill), 1);
    check("mid_left", 32'(readdata_left), 'h0A0B0C);
    check("mid_right", 32'(readdata_right), 'h0D0E0F);

    // Reset during the 10th bit of a left word
    apply_reset();
    preamble();
    send_frame(24'h111111, 24'h222222);
    slot(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) slot(1'b0, 1'b1);
    bclk = 1'b0;
    dat  = 1'b1;
    repeat (4) @(negedge clk);
    check("pre_rst_fill", 32'(fill), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(read_ready), 0);
    check("mid_rst_fill", 32'(fill), 0);
    check("mid_rst_left", 32'(readdata_left), 0);
    check("mid_rst_right", 32'(readdata_right), 0);
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (8) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) slot(1'b0, 1'b1);
    send_chan(1'b1, 24'h555555, 24, 32);
    send_frame(24'h345678, 24'h9ABCDE);
    tail();
    check("post_rst_fill", 32'(fill), 1);
    check("post_rst_left", 32'(readdata_left), 'h345678);
    check("post_rst_right", 32'(readdata_right), 'h9ABCDE);

`ifdef I2S_RX_PEAK_EN
    apply_reset();
    check("pk_rst", 32'(peak), 0);
    preamble();
    send_frame(24'h000100, 24'hFFFF00);
    tail();
    check("pk_val", 32'(peak), 'h000100);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    check("pk_clr", 32'(peak), 0);
    send_chan(1'b1, 24'h0, 0, 2);
    send_frame(24'h800000, 24'h000001);
    tail();
    check("pk_sat", 32'(peak), 'h7FFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2s_adc_receiver.md
I2S_ADC_RECEIVER -- requirements
Module: i2s_adc_receiver

Interface
REQ-001 Parameter: DATA_W, 24, sample width in bits per channel.
REQ-002 Parameter: FIFO_DEPTH, 4, stereo pairs buffered (power of two, >=2).
REQ-003 clk  input  1  system clock (50 MHz); all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 AUD_BCLK  input  1  codec bit clock, asynchronous to clk.
REQ-006 AUD_ADCLRCK  input  1  codec ADC word select, asynchronous; low = left, high = right.
REQ-007 AUD_ADCDAT  input  1  codec ADC serial data, MSB first, I2S format.
REQ-008 read  input  1  pop request; acts only while read_ready=1.
REQ-009 read_ready  output  1  FIFO holds at least one stereo pair.
REQ-010 readdata_left  output  DATA_W  head-of-FIFO left sample.
REQ-011 readdata_right  output  DATA_W  head-of-FIFO right sample.
REQ-012 fill  output  $clog2(FIFO_DEPTH)+1  stereo pairs currently stored.
REQ-013 overflow  output  1  sticky; a completed pair was dropped because the FIFO was full.

Function
REQ-014 BCLK, LRCK and DAT shall each pass through a 2-flop synchronizer; a third BCLK/LRCK stage shall provide edge detection.
REQ-015 All serial sampling shall occur on the clk cycle a synchronized BCLK rising edge is detected; DAT and LRCK values from that same synchronized cycle shall be used.
REQ-016 FSM states: SYNC, SKIP, SHIFT, HOLD.
REQ-017 SYNC: after reset, ignore data until the first LRCK falling edge (start of left word), then go to SKIP.
REQ-018 SKIP: consume exactly one BCLK rising edge (I2S one-bit delay), then go to SHIFT with the bit counter at 0.
REQ-019 SHIFT: shift DAT into the word register MSB first on each BCLK rising edge; after DATA_W bits go to HOLD.
REQ-020 HOLD: ignore further bits until the next LRCK edge.
REQ-021 An LRCK edge in SHIFT before DATA_W bits shall end the word, left-align the received bits and zero-fill the remaining LSBs.
REQ-022 At an LRCK rising edge, the completed word shall be latched as the left sample; FSM to SKIP.
REQ-023 At an LRCK falling edge, the completed word is the right sample; the {left, right} pair shall be pushed in that cycle; FSM to SKIP.
REQ-024 read_ready shall rise the clk cycle after the first push into an empty FIFO.
REQ-025 readdata_* shall be first-word-fall-through: valid whenever read_ready=1, advancing the cycle after a pop.
REQ-026 read with read_ready=0 shall be ignored; fill shall never underflow.
REQ-027 Push when full and no pop in the same cycle: drop the new pair, set overflow, leave contents unchanged.
REQ-028 Simultaneous push and pop when full: both succeed; fill unchanged; overflow not set.
REQ-029 Simultaneous push and pop when empty: push succeeds, pop ignored; fill becomes 1.
REQ-030 FIFO pointers shall wrap modulo FIFO_DEPTH.

Reset
REQ-031 Asserting reset_n=0 shall immediately force: FSM=SYNC, synchronizers=0, fill=0, read_ready=0, readdata_*=0, overflow=0, pointers=0.
REQ-032 Reset mid-word shall discard the partial word and any held left sample; the next pushed pair shall start from a fresh left word.

Configuration
REQ-033 Macro I2S_RX_PEAK_EN: when defined, add output peak [DATA_W-2:0] and input peak_clr [1]; peak shall track the maximum two's-complement magnitude of pushed left/right samples (-2^(DATA_W-1) saturates to all ones), update the cycle after a push, and reset to 0 on reset_n or peak_clr (peak_clr wins over a same-cycle update).
REQ-034 Without I2S_RX_PEAK_EN, the peak and peak_clr ports and their logic shall be absent; all other behaviour is identical.

Verification
REQ-035 I2S frame, BCLK=clk/16, left=24'h123456, right=24'hABCDEF -> read_ready=1, readdata_left=24'h123456, readdata_right=24'hABCDEF, fill=1.
REQ-036 5 frames, no read (DEPTH=4) -> fill=4, overflow=1; pops return frames 1-4 in order; the 5th frame is absent.
REQ-037 16-bit frame (LRCK toggles after 16 bits), left bits 16'hBEEF -> readdata_left=24'hBEEF00.
REQ-038 Stream starting mid-right-word -> first pushed pair is the first full left/right pair; no partial data appears.
REQ-039 reset_n pulsed low during the 10th bit of a left word -> all outputs 0 immediately; the next complete frame is received correctly.
REQ-040 I2S_RX_PEAK_EN, samples 24'h000100 and 24'hFFFF00 -> peak=23'h000100; peak_clr pulse -> peak=0.
